id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
ID/EX pipeline register and operand-select stage that directly feeds the 64-bit ALU in the execute stage. Registers decoded operands and control, and derives the registered 4-bit ALU control code from ALUOp/funct3/funct7[5]. Produces forwarded ALU operands A/B from the EX/MEM and MEM/WB results. Detects load-use hazards and inserts the bubble itself.

Parameters:
XLEN, 64, datapath width (matches ALU operand width)
RA_W, 5, register address width
CNT_W, 32, width of bubble performance counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
stall  in  1  hold all ID/EX registers this cycle
flush  in  1  replace next ID/EX contents with bubble
id_valid  in  1  ID stage holds a real instruction
id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decoded operands
id_rs1, id_rs2, id_rd  in  RA_W each  register addresses
id_alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
id_funct3  in  3  instruction funct3
id_funct7_b5  in  1  instruction bit 30
id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  control flags
exmem_reg_write, memwb_reg_write  in  1 each  forwarding source write enables
exmem_rd, memwb_rd  in  RA_W each  forwarding destination addresses
exmem_result, memwb_result  in  XLEN each  forwarding data
load_use_hazard  out  1  combinational; upstream holds PC and IF/ID while high
ex_valid  out  1  registered instruction-valid
alu_a, alu_b  out  XLEN each  ALU operands A and B (combinational from registered state plus forwarding)
alu_control  out  4  registered ALU control code
ex_store_data  out  XLEN  forwarded rs2 value
ex_pc, ex_imm  out  XLEN each  registered
ex_rd  out  RA_W  registered destination
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered control
bubble_count  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (async, immediate): ex_valid=0; all control flags=0; ex_rd=0; all data registers=0; alu_control=4'b0010; bubble_count=0.
- Bubble contents: same values as reset. bubble_count is not affected.
- Per-edge priority:
  - flush loads a bubble.
  - Else stall holds all registers.
  - Else load_use_hazard loads a bubble and increments bubble_count.
  - Else ID inputs are captured and ex_valid<=id_valid.
- flush+stall together: flush wins.
- load_use_hazard = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2). No bubble is inserted while stall is high.
- bubble_count saturates at all-ones; it does not wrap.
- ALU control decode, registered on capture:
  - alu_op 00 -> 0010 (add).
  - alu_op 01 -> 0110 (sub).
  - alu_op 10, funct3: 000 -> 0010 if funct7_b5=0, 0110 if 1; 111 -> 0000; 110 -> 0001; 100 -> 0100; 001 -> 1000; 101 -> 1001 if funct7_b5=0, 1010 if 1; 010/011 -> 1111.
  - alu_op 11: as alu_op 10, except funct3 000 is always 0010 (funct7_b5 ignored).
  - 1111 is an unsupported code; the ALU returns 0 for it.
- Forwarding for registered rs1 and rs2, evaluated independently, zero added latency:
  - EX/MEM is used if exmem_reg_write & exmem_rd!=0 & exmem_rd==rs.
  - Else MEM/WB is used if memwb_reg_write & memwb_rd!=0 & memwb_rd==rs.
  - Else the registered data is used.
  - EX/MEM has priority when both match.
  - Register x0 is never forwarded.
- Operand select: alu_a = fwd_rs1; alu_b = ex_alu_src ? ex_imm : fwd_rs2; ex_store_data = fwd_rs2 always.
- Latency: ID inputs appear on ex_* one cycle after capture. alu_a and alu_b follow forwarding inputs in the same cycle.

Test Plan:
- Reset mid-stream with ex_valid=1 -> all outputs clear asynchronously, before the next edge; alu_control=0010, bubble_count=0.
- R-type sub: alu_op=10, funct3=000, f7b5=1, rs1_data=10, rs2_data=3 -> next cycle alu_control=0110, alu_a=10, alu_b=3. Repeat with alu_op=11, f7b5=1 -> 0010.
- Decode sweep: f3=101/f7b5=1 -> 1010; f3=001 -> 1000; f3=010 -> 1111.
- Double hazard forwarding on rs1=5: exmem_rd=5 with result 0xAA and memwb_rd=5 with result 0xBB, both write enables set -> alu_a=0xAA. Drop exmem_reg_write -> alu_a=0xBB. rs1=0 with exmem_rd=0 -> registered data, not 0xAA.
- Load-use: EX holds ld x7 (mem_read=1), ID has rs2=7 and id_valid=1 -> load_use_hazard=1; next cycle ex_valid=0 and bubble_count=1. Same setup with stall=1 -> registers held, count unchanged.
- flush and stall asserted together -> bubble loaded. Preload bubble_count to all-ones and trigger a hazard -> count stays all-ones.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with ALU decode, operand forwarding and load-use bubble insertion
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [1:0]      id_alu_op,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_b5,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic            id_branch,
    input  logic            exmem_reg_write,
    input  logic            memwb_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [XLEN-1:0] memwb_result,
    output logic            load_use_hazard,
    output logic            ex_valid,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic [CNT_W-1:0] bubble_count
);

    localparam logic [3:0] ALU_ADD = 4'b0010;

    logic            r_valid;
    logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
    logic [RA_W-1:0] r_rs1, r_rs2, r_rd;
    logic            r_alu_src, r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg, r_branch;
    logic [3:0]      r_alu_control;
    logic [CNT_W-1:0] r_bubble_count;

    logic [3:0]      w_alu_control;
    logic            w_load_use;
    logic [XLEN-1:0] w_fwd_rs1, w_fwd_rs2;

    assign w_load_use = id_valid & r_valid & r_mem_read & (r_rd != '0) &
                        ((r_rd == id_rs1) | (r_rd == id_rs2));

    // I-type shares the R-type table except that bit 30 never selects sub
    always_comb begin
        w_alu_control = ALU_ADD;
        case (id_alu_op)
            2'b00: w_alu_control = ALU_ADD;
            2'b01: w_alu_control = 4'b0110;
            default: begin
                case (id_funct3)
                    3'b000: w_alu_control = (id_alu_op == 2'b10 && id_funct7_b5) ? 4'b0110 : ALU_ADD;
                    3'b111: w_alu_control = 4'b0000;
                    3'b110: w_alu_control = 4'b0001;
                    3'b100: w_alu_control = 4'b0100;
                    3'b001: w_alu_control = 4'b1000;
                    3'b101: w_alu_control = id_funct7_b5 ? 4'b1010 : 4'b1001;
                    default: w_alu_control = 4'b1111;
                endcase
            end
        endcase
    end

    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == r_rs1)
            w_fwd_rs1 = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == r_rs1)
            w_fwd_rs1 = memwb_result;

        w_fwd_rs2 = r_rs2_data;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == r_rs2)
            w_fwd_rs2 = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == r_rs2)
            w_fwd_rs2 = memwb_result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;       r_pc <= '0;          r_rs1_data <= '0;
            r_rs2_data <= '0;      r_imm <= '0;         r_rs1 <= '0;
            r_rs2 <= '0;           r_rd <= '0;          r_alu_src <= 1'b0;
            r_reg_write <= 1'b0;   r_mem_read <= 1'b0;  r_mem_write <= 1'b0;
            r_mem_to_reg <= 1'b0;  r_branch <= 1'b0;    r_alu_control <= ALU_ADD;
            r_bubble_count <= '0;
        end else if (flush || (!stall && w_load_use)) begin
            r_valid <= 1'b0;       r_pc <= '0;          r_rs1_data <= '0;
            r_rs2_data <= '0;      r_imm <= '0;         r_rs1 <= '0;
            r_rs2 <= '0;           r_rd <= '0;          r_alu_src <= 1'b0;
            r_reg_write <= 1'b0;   r_mem_read <= 1'b0;  r_mem_write <= 1'b0;
            r_mem_to_reg <= 1'b0;  r_branch <= 1'b0;    r_alu_control <= ALU_ADD;
            // Only hazard bubbles are counted, and the counter sticks at all-ones
            if (!flush && r_bubble_count != '1)
                r_bubble_count <= r_bubble_count + 1'b1;
        end else if (!stall) begin
            r_valid <= id_valid;           r_pc <= id_pc;
            r_rs1_data <= id_rs1_data;     r_rs2_data <= id_rs2_data;
            r_imm <= id_imm;               r_rs1 <= id_rs1;
            r_rs2 <= id_rs2;               r_rd <= id_rd;
            r_alu_src <= id_alu_src;       r_reg_write <= id_reg_write;
            r_mem_read <= id_mem_read;     r_mem_write <= id_mem_write;
            r_mem_to_reg <= id_mem_to_reg; r_branch <= id_branch;
            r_alu_control <= w_alu_control;
        end
    end

    assign load_use_hazard = w_load_use;
    assign ex_valid        = r_valid;
    assign alu_a           = w_fwd_rs1;
    assign alu_b           = r_alu_src ? r_imm : w_fwd_rs2;
    assign alu_control     = r_alu_control;
    assign ex_store_data   = w_fwd_rs2;
    assign ex_pc           = r_pc;
    assign ex_imm          = r_imm;
    assign ex_rd           = r_rd;
    assign ex_reg_write    = r_reg_write;
    assign ex_mem_read     = r_mem_read;
    assign ex_mem_write    = r_mem_write;
    assign ex_mem_to_reg   = r_mem_to_reg;
    assign ex_branch       = r_branch;
    assign bubble_count    = r_bubble_count;

endmodule
